// File: rtl/addsub_pkg.sv
// Shared definitions for the add/sub arbiter slice.
//   W_DATA        : datapath width of the shared adder/subtractor
//   OP_ADD/OP_SUB : encoding of the per-requester operation bit
//   state_e       : response-register occupancy state
//   sub_overflow  : signed overflow of A-B from the original operands
package addsub_pkg;

  localparam int W_DATA = 16;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } state_e;

  // A-B overflows when the operands differ in sign and the result sign
  // differs from A. Using the original B keeps this correct for B=0x8000,
  // whose two's-complement negation wraps back to 0x8000.
  function automatic logic sub_overflow(input logic [W_DATA-1:0] a,
                                        input logic [W_DATA-1:0] b,
                                        input logic [W_DATA-1:0] r);
    return (a[W_DATA-1] != b[W_DATA-1]) && (r[W_DATA-1] != a[W_DATA-1]);
  endfunction

endpackage

// File: rtl/addsub_arbiter_add_sub.sv
// Add_Sub: shared 16-bit two's-complement adder. Subtraction is performed
// by the caller presenting an already-negated B.
//   a_i, b_i : operands
//   sum_o    : a_i + b_i modulo 2^16
//   ovf_o    : signed overflow of the addition
module Add_Sub
  import addsub_pkg::*;
(
  input  logic [W_DATA-1:0] a_i,
  input  logic [W_DATA-1:0] b_i,
  output logic [W_DATA-1:0] sum_o,
  output logic              ovf_o
);

  assign sum_o = a_i + b_i;
  assign ovf_o = (a_i[W_DATA-1] == b_i[W_DATA-1]) &&
                 (sum_o[W_DATA-1] != a_i[W_DATA-1]);

endmodule

// File: rtl/addsub_arbiter_rr_grant.sv
// rr_grant: round-robin one-hot picker.
//   valid_i : request vector
//   ptr_i   : highest-priority index; search ascends from here with wrap
//   en_i    : when low, no grant is issued
//   grant_o : one-hot grant (all zero if disabled or nothing valid)
module rr_grant #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid_i,
  input  logic [PW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  grant_o
);

  logic found;
  int   idx;

  // NOTE: every variable assigned in this block gets a value before any
  // conditional, so no path leaves it holding state and no latch is inferred.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= N) idx = idx - N;
      if (en_i && !found && valid_i[idx[PW-1:0]]) begin
        grant_o[idx[PW-1:0]] = 1'b1;
        found                = 1'b1;
      end
    end
  end

endmodule

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin sequencer sharing one Add_Sub unit among
// NUM_REQ requesters, with a single-entry registered response.
//   req_valid/req_ready : per-requester handshake (req_ready one-hot)
//   req_op              : 0 = A+B, 1 = A-B
//   req_a/req_b         : packed operands, requester i at [16i+15:16i]
//   rsp_valid/rsp_ready : response handshake
//   rsp_id              : requester that owns the response
//   rsp_result          : A +/- B modulo 2^16
//   rsp_overflow        : signed overflow of the operation
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int W       = 16,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [NUM_REQ-1:0]   req_op,
  input  logic [NUM_REQ*W-1:0] req_a,
  input  logic [NUM_REQ*W-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [W-1:0]         rsp_result,
  output logic                 rsp_overflow
);

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [W-1:0]    rsp_result_q, rsp_result_d;
  logic            rsp_overflow_q, rsp_overflow_d;

  logic            can_accept;
  logic            accept;
  logic [ID_W-1:0] gnt_idx;
  logic [W-1:0]    a_sel, b_sel, b_eff;
  logic            op_sel;
  logic [W-1:0]    unit_sum;
  logic            unit_ovf;
  logic            ovf_sel;

  // Gating with rst_n keeps grants off for the whole reset window, not just
  // after the state register has settled.
  assign can_accept = rst_n && ((state_q == ST_EMPTY) || rsp_ready);

  rr_grant #(
    .N  (NUM_REQ),
    .PW (ID_W)
  ) u_rr_grant (
    .valid_i (req_valid),
    .ptr_i   (rr_ptr_q),
    .en_i    (can_accept),
    .grant_o (req_ready)
  );

  // Grant already implies valid, so any grant bit is an accept.
  assign accept = |req_ready;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) gnt_idx = ID_W'(i);
    end
  end

  assign a_sel  = req_a[gnt_idx*W +: W];
  assign b_sel  = req_b[gnt_idx*W +: W];
  assign op_sel = req_op[gnt_idx];

  // Two's-complement negation ahead of the shared unit turns it into a
  // subtractor; this incrementer is in series with the unit's carry chain.
  assign b_eff = (op_sel == OP_SUB) ? (~b_sel + W'(1)) : b_sel;

  Add_Sub u_add_sub (
    .a_i   (a_sel),
    .b_i   (b_eff),
    .sum_o (unit_sum),
    .ovf_o (unit_ovf)
  );

  // The unit's overflow flag is wrong for sub when B=0x8000, so sub uses
  // the original operands instead.
  assign ovf_sel = (op_sel == OP_SUB) ? sub_overflow(a_sel, b_sel, unit_sum)
                                      : unit_ovf;

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    rsp_id_d       = rsp_id_q;
    rsp_result_d   = rsp_result_q;
    rsp_overflow_d = rsp_overflow_q;
    if (accept) begin
      state_d        = ST_FULL;
      rsp_id_d       = gnt_idx;
      rsp_result_d   = unit_sum;
      rsp_overflow_d = ovf_sel;
      rr_ptr_d       = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end else if ((state_q == ST_FULL) && rsp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the response payload is reset too, so outputs read zero
  // during and right after reset rather than stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_EMPTY;
      rr_ptr_q       <= '0;
      rsp_id_q       <= '0;
      rsp_result_q   <= '0;
      rsp_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      rsp_id_q       <= rsp_id_d;
      rsp_result_q   <= rsp_result_d;
      rsp_overflow_q <= rsp_overflow_d;
    end
  end

  assign rsp_valid    = (state_q == ST_FULL);
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_overflow = rsp_overflow_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed self-checking bench for addsub_arbiter (NUM_REQ=4).
module tb_addsub_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_op;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_result;
  logic           rsp_overflow;

  int checks = 0;
  int errors = 0;

  addsub_arbiter #(.NUM_REQ(N), .W(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_overflow (rsp_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic [1:0] id,
                           input logic [15:0] res, input logic ovf);
    check({tag, ".valid"}, 32'(rsp_valid), 32'(v));
    check({tag, ".id"}, 32'(rsp_id), 32'(id));
    check({tag, ".result"}, 32'(rsp_result), 32'(res));
    check({tag, ".ovf"}, 32'(rsp_overflow), 32'(ovf));
  endtask

  task automatic set_req(input int i, input logic op, input logic [15:0] a,
                         input logic [15:0] b);
    req_op[i]        = op;
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;

    // Reset state: nothing granted even with requests pending.
    req_valid = 4'b1111;
    #12;
    check("rst.ready", 32'(req_ready), 32'h0);
    check_rsp("rst", 1'b0, 2'd0, 16'h0000, 1'b0);
    req_valid = '0;
    step();
    rst_n = 1'b1;

    // Single add with overflow.
    rsp_ready = 1'b1;
    set_req(0, 1'b0, 16'h7FFF, 16'h0001);
    req_valid = 4'b0001;
    #1;
    check("add.ready", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    check_rsp("add", 1'b1, 2'd0, 16'h8000, 1'b1);

    // Sub 0 - 0x8000: ptr=1, req2 is first valid at/after it.
    set_req(2, 1'b1, 16'h0000, 16'h8000);
    req_valid = 4'b0100;
    #1;
    check("sub8000.ready", 32'(req_ready), 32'h4);
    step();
    check_rsp("sub8000", 1'b1, 2'd2, 16'h8000, 1'b1);

    // Sub 5 - 7 from req2 again (ptr=3 wraps to 2).
    set_req(2, 1'b1, 16'h0005, 16'h0007);
    #1;
    check("sub57.ready", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    check_rsp("sub57", 1'b1, 2'd2, 16'hFFFE, 1'b0);
    step();
    check("drain.valid", 32'(rsp_valid), 32'h0);

    // Backpressure: ptr=3, req1 accepted, then held for 5 cycles.
    rsp_ready = 1'b0;
    set_req(1, 1'b0, 16'h1234, 16'h0100);
    req_valid = 4'b0010;
    #1;
    check("bp.ready_empty", 32'(req_ready), 32'h2);
    step();
    set_req(1, 1'b0, 16'h4000, 16'h4000);
    for (int c = 0; c < 5; c++) begin
      check("bp.ready_held", 32'(req_ready), 32'h0);
      check_rsp("bp.frozen", 1'b1, 2'd1, 16'h1334, 1'b0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp.ready_release", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    check_rsp("bp.nobubble", 1'b1, 2'd1, 16'h8000, 1'b1);
    step();
    check("bp.empty", 32'(rsp_valid), 32'h0);

    // Sparse: ptr=2; req3 then req1.
    set_req(3, 1'b1, 16'h0001, 16'h0002);
    req_valid = 4'b1000;
    #1;
    check("sparse.r3", 32'(req_ready), 32'h8);
    step();
    check_rsp("sparse3", 1'b1, 2'd3, 16'hFFFF, 1'b0);
    set_req(1, 1'b1, 16'h8000, 16'h0001);
    req_valid = 4'b0010;
    #1;
    check("sparse.r1", 32'(req_ready), 32'h2);
    step();
    check_rsp("sparse1", 1'b1, 2'd1, 16'h7FFF, 1'b1);
    // Pointer now 2: with all valid and rsp_ready=1, req2 wins.
    req_valid = 4'b1111;
    #1;
    check("sparse.ptr2", 32'(req_ready), 32'h4);
    req_valid = '0;
    step();
    check("sparse.empty", 32'(rsp_valid), 32'h0);

    // Reset mid-operation while FULL and stalled.
    rsp_ready = 1'b0;
    set_req(0, 1'b0, 16'h7FFF, 16'h0001);
    req_valid = 4'b0001;
    step();
    check_rsp("midop.full", 1'b1, 2'd0, 16'h8000, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_rsp("midop.rst", 1'b0, 2'd0, 16'h0000, 1'b0);
    check("midop.ready", 32'(req_ready), 32'h0);
    step();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 16'(16'h1000 * i + 3), 16'h0010);
    req_valid = 4'b1111;
    #1;
    check("postrst.ready", 32'(req_ready), 32'h1);

    // Fairness: grants 0,1,2,3,0,1 back to back.
    for (int i = 0; i < 6; i++) begin
      check("rr.ready", 32'(req_ready), 32'(1 << (i % 4)));
      step();
      check_rsp("rr", 1'b1, 2'(i % 4), 16'(16'h1000 * (i % 4) + 16'h13), 1'b0);
    end
    req_valid = '0;
    step();
    check("rr.empty", 32'(rsp_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/addsub_arbiter.md
# addsub_arbiter

Round-robin arbiter and sequencer sharing one 16-bit two's-complement adder/subtractor (`Add_Sub`) among `NUM_REQ` ODE-solver requesters. It accepts one operation per cycle over valid/ready handshakes and drives the shared combinational unit. Subtraction is formed by negating B, and the result is registered with overflow and the requester ID. It sits between the solver stage controllers and the single arithmetic unit.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; 2..8.
- `W`, default 16: operand width; fixed at 16 by `Add_Sub`.

Ports:
- `clk`, in, 1: single clock; all state on rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `req_valid`, in, NUM_REQ: request valid per requester.
- `req_ready`, out, NUM_REQ: one-hot grant; operation accepted when `req_valid[i] & req_ready[i]`.
- `req_op`, in, NUM_REQ: per requester; 0 = A+B, 1 = A−B.
- `req_a`, in, NUM_REQ*16: operand A; requester i occupies bits [16i+15:16i].
- `req_b`, in, NUM_REQ*16: operand B; same packing as `req_a`.
- `rsp_valid`, out, 1: response register holds a result.
- `rsp_ready`, in, 1: downstream consumes the response when `rsp_valid & rsp_ready`.
- `rsp_id`, out, clog2(NUM_REQ): index of the requester that owns the result.
- `rsp_result`, out, 16: A±B modulo 2^16.
- `rsp_overflow`, out, 1: signed overflow of the operation.

## Operation
- FSM has 2 states:
  - EMPTY: response register is free.
  - FULL: response register is occupied.
- `can_accept` = EMPTY | (FULL & `rsp_ready`).
- Grant rules:
  - `req_ready` is all zero when `can_accept` = 0.
  - Otherwise `req_ready` is one-hot on the first valid requester at or after `rr_ptr`, searching ascending with wrap.
  - `req_ready` never asserts for an index whose `req_valid` = 0.
- On accept of requester g:
  - Drive the unit with A = `req_a[g]`, and B = `req_b[g]` for add or (~`req_b[g]` + 1) for sub.
  - Register the sum, overflow, and g.
  - Set `rr_ptr` = (g+1) mod NUM_REQ.
  - Next state is FULL.
- Overflow:
  - Add: taken from the unit, i.e. A[15]==B[15] and R[15]!=A[15].
  - Sub: computed locally from the original operands as A[15]!=B[15] and R[15]!=A[15].
  - Sub with B=0x8000 negates to 0x8000; the local formula still flags overflow correctly.
- FULL & `rsp_ready` & no valid requester: next state is EMPTY.
- FULL & !`rsp_ready`: hold all response outputs stable and grant nothing.
- Requester protocol: a requester holds `req_valid` and its operands stable until granted. The block does not check this.
- `rr_ptr` advances only on an accepted grant.
- Reset, asynchronous:
  - State goes to EMPTY, `rr_ptr` to 0, `rsp_valid` to 0.
  - `rsp_id`, `rsp_result` and `rsp_overflow` go to 0.
  - `req_ready` is 0 while `rst_n` is low.
  - An in-flight response is discarded; no partial handshake survives reset.

## Timing
- `req_ready` is combinational from `req_valid`, state, `rr_ptr` and `rsp_ready`. There is no path from `req_a`/`req_b` to `req_ready`.
- Latency: accept at edge t gives `rsp_valid`=1 with the result after edge t.
- Throughput: 1 operation/cycle while `rsp_ready` stays high.
- The negation incrementer plus the unit's ripple chain form the critical path. Both lie between the grant mux and the response register; no further pipelining.
- Simultaneous response drain and new accept in the same cycle stays FULL with the new data; no bubble.
- First cycle after `rst_n` rises: grants are allowed, and `rr_ptr`=0 gives requester 0 first priority.

## Structure
- Shared package `addsub_pkg`:
  - `W_DATA`=16.
  - `OP_ADD`=1'b0, `OP_SUB`=1'b1.
  - State enum {`ST_EMPTY`, `ST_FULL`}.
  - Signed-overflow function used for the sub path.
- One sub-module, `rr_grant`: a parameterised round-robin one-hot picker, (valid, ptr, enable) → grant.
- `Add_Sub` is instantiated once inside; it is not duplicated per requester.

## Test plan
1. Reset mid-operation: FULL with `rsp_ready`=0, assert `rst_n`=0 → `rsp_valid`=0, all outputs 0, `req_ready`=0 immediately. After release, requester 0 is granted first.
2. Single add, `rsp_ready`=1: req0 A=0x7FFF, B=0x0001, op=add → next cycle `rsp_result`=0x8000, `rsp_overflow`=1, `rsp_id`=0.
3. Subtract boundaries:
   - req2 A=0x0000, B=0x8000, sub → 0x8000, overflow=1.
   - A=0x0005, B=0x0007, sub → 0xFFFE, overflow=0.
4. Round-robin fairness: all 4 requesters valid continuously, `rsp_ready`=1 → grants 0,1,2,3,0,1… one per cycle, matching `rsp_id` sequence, no bubbles.
5. Backpressure: `rsp_ready`=0 for 5 cycles while FULL → `req_ready`=0 and response outputs frozen. On `rsp_ready`=1, drain and new accept occur in the same cycle.
6. Sparse requests: only req3 valid, then req1 → grant 3 then 1, `rr_ptr`=2 afterward. The FSM returns to EMPTY when no request is pending.
